// File: rtl/ps2_scancode_fifo_if.sv
// Consumer-side bundle of the PS/2 scancode queue: receive enable, pop/clear
// controls and the head entry plus status returned by the queue.
interface ps2_scancode_fifo_if #(
  parameter int unsigned AW = 4
);
  logic          enable_rcv;
  logic          pop;
  logic          clear_errors;
  logic [9:0]    dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          frame_error;

  // Consumer (register interface / keymap translator) side
  modport master (
    output enable_rcv, pop, clear_errors,
    input  dout, empty, full, count, overflow, frame_error
  );

  // Receiver/queue side
  modport slave (
    input  enable_rcv, pop, clear_errors,
    output dout, empty, full, count, overflow, frame_error
  );
endinterface

// File: rtl/ps2_scancode_fifo.sv
// PS/2 device-to-host receiver: synchronises and debounces the PS/2 lines,
// deserialises 11-bit frames, folds E0/F0 prefixes into flags and queues
// complete key events in a show-ahead FIFO of 2**AW entries.
module ps2_scancode_fifo #(
  parameter int unsigned AW      = 4,
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned DECODE  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ps2clk_i,
  input  logic                    ps2data_i,
  ps2_scancode_fifo_if.slave      bus
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DepthVal = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchroniser and filter state
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d, filt_prev_q;
  logic [7:0]    filt_cnt_q, filt_cnt_d;
  logic          bit_evt;

  // Frame FSM state
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          par_err_q, par_err_d;
  logic          byte_vld_q, byte_vld_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_err_pulse;

  // Decode and FIFO state
  logic          ext_q, ext_d, rel_q, rel_d;
  logic          push_req, push_ok, pop_eff, ovf_set;
  logic [9:0]    wdata;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          overflow_q, overflow_d, frame_error_q, frame_error_d;
  logic [9:0]    mem_q [Depth];

  // Debounce: the filtered clock follows only after FILTER identical samples
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == 8'(FILTER - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  assign bit_evt = filt_prev_q & ~filt_q;

  // Frame FSM next state, bit assembly and inter-bit timeout
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_d           = par_q;
    par_err_d       = par_err_q;
    byte_vld_d      = 1'b0;
    frame_err_pulse = 1'b0;
    if (state_q == StIdle || bit_evt) tmo_d = '0;
    else                              tmo_d = tmo_q + TW'(1);

    unique case (state_q)
      StIdle: begin
        if (bit_evt && bus.enable_rcv && !dat_s2_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end
      end
      StData: begin
        if (bit_evt) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          par_d     = par_q ^ dat_s2_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (bit_evt) begin
          // Odd parity over data + parity bit
          par_err_d = ~(par_q ^ dat_s2_q);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (bit_evt) begin
          state_d = StIdle;
          if (dat_s2_q && !par_err_q) byte_vld_d = 1'b1;
          else                        frame_err_pulse = 1'b1;
        end
      end
    endcase

    if (state_q != StIdle && !bit_evt && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d         = StIdle;
      frame_err_pulse = 1'b1;
      tmo_d           = '0;
    end
  end

  // Prefix folding, FIFO pointers/count and sticky error flags
  always_comb begin
    ext_d    = ext_q;
    rel_d    = rel_q;
    push_req = 1'b0;
    wdata    = {rel_q, ext_q, shift_q};
    if (frame_err_pulse) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_vld_q) begin
      if (DECODE != 0 && shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (DECODE != 0 && shift_q == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        push_req = 1'b1;
        ext_d    = 1'b0;
        rel_d    = 1'b0;
      end
    end

    pop_eff = bus.pop & (cnt_q != '0);
    // A simultaneous pop frees a slot, so a push into a full queue still fits
    push_ok = push_req & ((cnt_q != DepthVal) | pop_eff);
    ovf_set = push_req & ~push_ok;

    wptr_d = wptr_q + AW'(push_ok);
    rptr_d = rptr_q + AW'(pop_eff);
    cnt_d  = cnt_q;
    if (push_ok && !pop_eff)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_eff) cnt_d = cnt_q - 1'b1;

    overflow_d    = (overflow_q & ~bus.clear_errors) | ovf_set;
    frame_error_d = (frame_error_q & ~bus.clear_errors) | frame_err_pulse;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      dat_s1_q      <= 1'b1;
      dat_s2_q      <= 1'b1;
      filt_q        <= 1'b1;
      filt_prev_q   <= 1'b1;
      filt_cnt_q    <= '0;
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      par_err_q     <= 1'b0;
      byte_vld_q    <= 1'b0;
      tmo_q         <= '0;
      ext_q         <= 1'b0;
      rel_q         <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      clk_s1_q      <= ps2clk_i;
      clk_s2_q      <= clk_s1_q;
      dat_s1_q      <= ps2data_i;
      dat_s2_q      <= dat_s1_q;
      filt_q        <= filt_d;
      filt_prev_q   <= filt_q;
      filt_cnt_q    <= filt_cnt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      par_err_q     <= par_err_d;
      byte_vld_q    <= byte_vld_d;
      tmo_q         <= tmo_d;
      ext_q         <= ext_d;
      rel_q         <= rel_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Queue storage; contents are masked by empty so it needs no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

  assign bus.empty       = (cnt_q == '0);
  assign bus.full        = (cnt_q == DepthVal);
  assign bus.count       = cnt_q;
  assign bus.dout        = (cnt_q == '0) ? 10'd0 : mem_q[rptr_q];
  assign bus.overflow    = overflow_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Directed bench for ps2_scancode_fifo: a decoding instance (AW=2) and a raw
// instance share the PS/2 lines; each task drives frames and checks inline.
module tb_ps2_scancode_fifo;

  localparam int unsigned AW      = 2;
  localparam int unsigned FILTER  = 8;
  localparam int unsigned TIMEOUT = 200;
  localparam int          HALF    = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ps2_scancode_fifo_if #(.AW(AW)) bi ();
  ps2_scancode_fifo_if #(.AW(AW)) br ();

  ps2_scancode_fifo #(.AW(AW), .FILTER(FILTER), .TIMEOUT(TIMEOUT), .DECODE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2clk_i  (ps2clk),
    .ps2data_i (ps2data),
    .bus       (bi)
  );

  ps2_scancode_fifo #(.AW(AW), .FILTER(FILTER), .TIMEOUT(TIMEOUT), .DECODE(0)) dut_raw (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2clk_i  (ps2clk),
    .ps2data_i (ps2data),
    .bus       (br)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic ps2_bit(input logic b);
    ps2data = b;
    tick(4);
    ps2clk = 1'b0;
    tick(HALF);
    ps2clk = 1'b1;
    tick(HALF);
  endtask

  // Sends the first nbits of {stop, parity, data, start}, LSB (start) first.
  // enable_rcv drops just before bit index drop_at (negative = never).
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits,
                           input int drop_at);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) bi.enable_rcv = 1'b0;
      ps2_bit(fr[i]);
    end
  endtask

  // Stop bit with latency measurement; pop is raised for the edge numbered pop_at
  task automatic stop_bit(input int pop_at, output int lat);
    ps2data = 1'b1;
    tick(4);
    ps2clk = 1'b0;
    lat = -1;
    for (int i = 1; i <= HALF; i++) begin
      if (i == pop_at) bi.pop = 1'b1;
      tick(1);
      bi.pop = 1'b0;
      if (lat < 0 && !bi.empty) lat = i;
    end
    ps2clk = 1'b1;
    tick(HALF);
  endtask

  task automatic pop_i();
    bi.pop = 1'b1;
    tick(1);
    bi.pop = 1'b0;
  endtask

  task automatic pop_r();
    br.pop = 1'b1;
    tick(1);
    br.pop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bi.empty !== 1'b1) begin fails++;
      $display("FAIL reset_empty got %b want 1", bi.empty); end
    tests++; if (bi.full !== 1'b0) begin fails++;
      $display("FAIL reset_full got %b want 0", bi.full); end
    tests++; if (bi.count !== 3'd0) begin fails++;
      $display("FAIL reset_count got %0d want 0", bi.count); end
    tests++; if (bi.dout !== 10'h000) begin fails++;
      $display("FAIL reset_dout got %h want 000", bi.dout); end
    tests++; if (bi.overflow !== 1'b0 || bi.frame_error !== 1'b0) begin fails++;
      $display("FAIL reset_errs got %b%b want 00", bi.overflow, bi.frame_error); end
  endtask

  task automatic test_clean();
    int lat;
    send_bits(8'h1C, 1'b0, 10, -1);
    stop_bit(0, lat);
    tests++; if (lat != FILTER + 4) begin fails++;
      $display("FAIL clean_latency got %0d want %0d", lat, FILTER + 4); end
    tests++; if (bi.dout !== 10'h01C) begin fails++;
      $display("FAIL clean_dout got %h want 01c", bi.dout); end
    tests++; if (bi.count !== 3'd1) begin fails++;
      $display("FAIL clean_count got %0d want 1", bi.count); end
    pop_i();
    tests++; if (bi.empty !== 1'b1) begin fails++;
      $display("FAIL clean_pop_empty got %b want 1", bi.empty); end
  endtask

  task automatic test_prefix();
    logic [9:0] raw_exp [3];
    raw_exp[0] = 10'h0E0;
    raw_exp[1] = 10'h0F0;
    raw_exp[2] = 10'h075;
    do_reset();
    send_bits(8'hE0, 1'b0, 11, -1);
    send_bits(8'hF0, 1'b0, 11, -1);
    send_bits(8'h75, 1'b0, 11, -1);
    tests++; if (bi.count !== 3'd1) begin fails++;
      $display("FAIL prefix_count got %0d want 1", bi.count); end
    tests++; if (bi.dout !== 10'h375) begin fails++;
      $display("FAIL prefix_dout got %h want 375", bi.dout); end
    tests++; if (br.count !== 3'd3) begin fails++;
      $display("FAIL raw_count got %0d want 3", br.count); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (br.dout !== raw_exp[i]) begin fails++;
        $display("FAIL raw_entry%0d got %h want %h", i, br.dout, raw_exp[i]); end
      pop_r();
    end
    pop_i();
    send_bits(8'h75, 1'b0, 11, -1);
    tests++; if (bi.dout !== 10'h075) begin fails++;
      $display("FAIL plain_after_prefix got %h want 075", bi.dout); end
    pop_i();
  endtask

  task automatic test_errors();
    do_reset();
    send_bits(8'h1C, 1'b1, 11, -1);
    tests++; if (bi.frame_error !== 1'b1) begin fails++;
      $display("FAIL parity_error got %b want 1", bi.frame_error); end
    tests++; if (bi.empty !== 1'b1) begin fails++;
      $display("FAIL parity_no_push got empty=%b want 1", bi.empty); end
    bi.clear_errors = 1'b1;
    tick(1);
    bi.clear_errors = 1'b0;
    tests++; if (bi.frame_error !== 1'b0) begin fails++;
      $display("FAIL clear_errors got %b want 0", bi.frame_error); end
    send_bits(8'h29, 1'b0, 5, -1);
    tests++; if (bi.frame_error !== 1'b0) begin fails++;
      $display("FAIL early_timeout got %b want 0", bi.frame_error); end
    tick(TIMEOUT + 50);
    tests++; if (bi.frame_error !== 1'b1) begin fails++;
      $display("FAIL timeout_error got %b want 1", bi.frame_error); end
    bi.clear_errors = 1'b1;
    tick(1);
    bi.clear_errors = 1'b0;
    send_bits(8'h29, 1'b0, 11, -1);
    tests++; if (bi.dout !== 10'h029 || bi.count !== 3'd1) begin fails++;
      $display("FAIL after_timeout got %h/%0d want 029/1", bi.dout, bi.count); end
    tests++; if (bi.frame_error !== 1'b0) begin fails++;
      $display("FAIL after_timeout_err got %b want 0", bi.frame_error); end
    pop_i();
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5];
    logic [9:0] exp_q [4];
    int lat;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_q = '{10'h022, 10'h033, 10'h044, 10'h066};
    do_reset();
    for (int i = 0; i < 5; i++) send_bits(bytes[i], 1'b0, 11, -1);
    tests++; if (bi.count !== 3'd4 || bi.full !== 1'b1) begin fails++;
      $display("FAIL ovf_count got %0d/%b want 4/1", bi.count, bi.full); end
    tests++; if (bi.overflow !== 1'b1) begin fails++;
      $display("FAIL ovf_flag got %b want 1", bi.overflow); end
    tests++; if (bi.dout !== 10'h011) begin fails++;
      $display("FAIL ovf_head got %h want 011", bi.dout); end
    bi.clear_errors = 1'b1;
    tick(1);
    bi.clear_errors = 1'b0;
    // Pop lands on the push edge of frame 66
    send_bits(8'h66, 1'b0, 10, -1);
    stop_bit(FILTER + 4, lat);
    tests++; if (bi.count !== 3'd4 || bi.overflow !== 1'b0) begin fails++;
      $display("FAIL push_pop_full got %0d/%b want 4/0", bi.count, bi.overflow); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (bi.dout !== exp_q[i]) begin fails++;
        $display("FAIL ovf_entry%0d got %h want %h", i, bi.dout, exp_q[i]); end
      pop_i();
    end
    tests++; if (bi.empty !== 1'b1) begin fails++;
      $display("FAIL ovf_drain got empty=%b want 1", bi.empty); end
  endtask

  task automatic test_glitch_enable();
    do_reset();
    ps2data = 1'b0;
    tick(4);
    ps2clk = 1'b0;
    tick(3);
    ps2clk = 1'b1;
    tick(20);
    send_bits(8'h34, 1'b0, 11, -1);
    tests++; if (bi.dout !== 10'h034 || bi.count !== 3'd1) begin fails++;
      $display("FAIL glitch got %h/%0d want 034/1", bi.dout, bi.count); end
    pop_i();
    bi.enable_rcv = 1'b0;
    send_bits(8'h45, 1'b0, 11, -1);
    bi.enable_rcv = 1'b1;
    tests++; if (bi.empty !== 1'b1 || bi.frame_error !== 1'b0) begin fails++;
      $display("FAIL disabled got %b/%b want 1/0", bi.empty, bi.frame_error); end
    send_bits(8'h4B, 1'b0, 11, 3);
    bi.enable_rcv = 1'b1;
    tests++; if (bi.dout !== 10'h04B || bi.count !== 3'd1) begin fails++;
      $display("FAIL enable_drop got %h/%0d want 04b/1", bi.dout, bi.count); end
    pop_i();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_bits(8'h12, 1'b0, 11, -1);
    send_bits(8'h13, 1'b0, 11, -1);
    send_bits(8'hE0, 1'b0, 11, -1);
    tests++; if (bi.count !== 3'd2) begin fails++;
      $display("FAIL mid_pre_count got %0d want 2", bi.count); end
    send_bits(8'h77, 1'b0, 6, -1);
    do_reset();
    tests++; if (bi.empty !== 1'b1 || bi.count !== 3'd0) begin fails++;
      $display("FAIL mid_reset got %b/%0d want 1/0", bi.empty, bi.count); end
    send_bits(8'h5A, 1'b0, 11, -1);
    tests++; if (bi.dout !== 10'h05A || bi.count !== 3'd1) begin fails++;
      $display("FAIL mid_next got %h/%0d want 05a/1", bi.dout, bi.count); end
    tests++; if (bi.frame_error !== 1'b0) begin fails++;
      $display("FAIL mid_err got %b want 0", bi.frame_error); end
  endtask

  initial begin
    bi.enable_rcv   = 1'b1;
    bi.pop          = 1'b0;
    bi.clear_errors = 1'b0;
    br.enable_rcv   = 1'b1;
    br.pop          = 1'b0;
    br.clear_errors = 1'b0;
    test_reset();
    test_clean();
    test_prefix();
    test_errors();
    test_overflow();
    test_glitch_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
